// File: rtl/fifo_rr_reader_pkg.sv
// rtl/fifo_rr_reader_pkg.sv - shared constants and helpers for the four-lane FIFO read controller
package fifo_rr_reader_pkg;

    localparam int N     = 4;
    localparam int PTR_W = 2;

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_IDLE   = 5'b00010;
    localparam logic [4:0] ST_ACTIVE = 5'b00100;
    localparam logic [4:0] ST_PAUSE  = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;

    // Lane 3 as the reset grant makes lane 0 the first one searched.
    localparam logic [PTR_W-1:0] LAST_GRANT_RST = 2'd3;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rr_reader_arbiter.sv
// rtl/fifo_rr_reader_arbiter.sv - combinational 4-way rotating priority arbiter
module rr_arbiter4
    import fifo_rr_reader_pkg::*;
(
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_last_grant,
    output logic [N-1:0]     o_grant,
    output logic             o_grant_valid
);

    logic [PTR_W-1:0] w_idx;

    // Search starts just past the last winner; the 2-bit index wraps 3 -> 0 on its own.
    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        w_idx         = i_last_grant;
        for (int k = 0; k < N; k++) begin
            w_idx = w_idx + 2'd1;
            if (!o_grant_valid && i_eligible[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_reader.sv
// rtl/fifo_rr_reader.sv - round-robin pop controller draining four FIFOs into one registered stream
module fifo_rr_reader
    import fifo_rr_reader_pkg::*;
#(
    parameter int DW = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N-1:0]      i_fifo_empty,
    input  logic [N-1:0]      i_fifo_error,
    input  logic [N*DW-1:0]   i_fifo_data,
    input  logic              i_pause,
    output logic [N-1:0]      o_pop,
    output logic [DW-1:0]     o_data_out,
    output logic              o_valid_out,
    output logic [PTR_W-1:0]  o_lane_out,
    output logic              o_error_out,
    output logic [4:0]        o_state_out
);

    logic [4:0]       r_state;
    logic [PTR_W-1:0] r_last_grant;
    logic [N-1:0]     r_prev_pop;
    logic             r_inflight_vld;
    logic [PTR_W-1:0] r_inflight_lane;
    logic [DW-1:0]    r_data;
    logic [PTR_W-1:0] r_lane;
    logic             r_valid;

    logic [N-1:0]     w_eligible;
    logic [N-1:0]     w_grant;
    logic             w_grant_valid;
    logic [PTR_W-1:0] w_grant_idx;
    logic             w_pop_en;
    logic [N-1:0]     w_pop;
    logic [N-1:0]     w_elig_nxt;
    logic [4:0]       w_state_nxt;
    logic [DW-1:0]    w_rd_word;

    // The empty flag lags a pop by one cycle, so the lane just popped is masked out.
    assign w_eligible = ~i_fifo_empty & ~r_prev_pop;

    rr_arbiter4 u_arb (
        .i_eligible    (w_eligible),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    assign w_grant_idx = onehot_to_idx(w_grant);
    assign w_pop_en    = ((r_state == ST_ACTIVE) || (r_state == ST_PAUSE)) && !i_pause;
    assign w_pop       = (w_pop_en && w_grant_valid) ? w_grant : '0;

    // Next-state decisions look at what will be eligible next cycle, so a lone lane alternates.
    assign w_elig_nxt  = ~i_fifo_empty & ~w_pop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET: w_state_nxt = ST_IDLE;
            ST_ERROR: w_state_nxt = ST_ERROR;
            default: begin
                if (|i_fifo_error)     w_state_nxt = ST_ERROR;
                else if (i_pause)      w_state_nxt = ST_PAUSE;
                else if (|w_elig_nxt)  w_state_nxt = ST_ACTIVE;
                else                   w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < N; i++) begin
            if (r_inflight_lane == PTR_W'(i)) w_rd_word = i_fifo_data[i*DW +: DW];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_RESET;
            r_last_grant    <= LAST_GRANT_RST;
            r_prev_pop      <= '0;
            r_inflight_vld  <= 1'b0;
            r_inflight_lane <= '0;
            r_data          <= '0;
            r_lane          <= '0;
            r_valid         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_prev_pop      <= w_pop;
            r_inflight_vld  <= |w_pop;
            r_inflight_lane <= w_grant_idx;
            r_valid         <= r_inflight_vld;
            if (|w_pop) r_last_grant <= w_grant_idx;
            if (r_inflight_vld) begin
                r_data <= w_rd_word;
                r_lane <= r_inflight_lane;
            end
        end
    end

    assign o_pop       = w_pop;
    assign o_data_out  = r_data;
    assign o_valid_out = r_valid;
    assign o_lane_out  = r_lane;
    assign o_error_out = (r_state == ST_ERROR);
    assign o_state_out = r_state;

endmodule
